// File: rtl/tetris_pixel_renderer.sv
// tetris_pixel_renderer
//   Overlays NUM_BLOCKS falling-piece cells onto the background pixel stream
//   coming from the VGA address generator / background ROM. Every cell is a
//   CELL_SIZE square drawn in a per-type palette colour with a 1-pixel black
//   outline. Cell positions are double-buffered and committed at frame start.
//   A game-over mode blinks the cells every 2^BLINK_LOG2 frames.
//   The pipeline has a fixed latency of 3 cycles and never stalls.
//
// Ports
//   clock          system clock, rising edge
//   resetn         asynchronous active-low reset
//   address        current pixel address (y*H_RES + x)
//   addr_valid     address/color_in valid this cycle
//   color_in       background colour for address
//   blk_x, blk_y   packed cell origins, block i at [i*COORD_W +: COORD_W]
//   blk_type       piece type shared by all cells
//   pos_load       one-cycle pulse capturing blk_x/blk_y/blk_type
//   game_over      level, enables blinking
//   color_out      final pixel colour
//   color_valid    color_out valid (addr_valid delayed by 3)
//   frame_count    frames started since reset, wraps
//   update_pending captured position not yet committed
module tetris_pixel_renderer #(
  parameter int NUM_BLOCKS = 4,
  parameter int CELL_SIZE  = 20,
  parameter int COORD_W    = 10,
  parameter int ADDR_W     = 19,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 24,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [ADDR_W-1:0]             address,
  input  logic                          addr_valid,
  input  logic [COLOR_W-1:0]            color_in,
  input  logic [NUM_BLOCKS*COORD_W-1:0] blk_x,
  input  logic [NUM_BLOCKS*COORD_W-1:0] blk_y,
  input  logic [2:0]                    blk_type,
  input  logic                          pos_load,
  input  logic                          game_over,
  output logic [COLOR_W-1:0]            color_out,
  output logic                          color_valid,
  output logic [7:0]                    frame_count,
  output logic                          update_pending
);

  localparam int unsigned NPIX = H_RES * V_RES;
  localparam int unsigned PW   = (COLOR_W < 24) ? COLOR_W : 24;
  localparam int unsigned BW   = NUM_BLOCKS * COORD_W;

  localparam logic [COORD_W:0]   CELL_EXT  = (COORD_W+1)'(CELL_SIZE);
  localparam logic [COORD_W-1:0] CELL_LAST = COORD_W'(CELL_SIZE - 1);

  function automatic logic [COLOR_W-1:0] palette(input logic [2:0] t);
    logic [23:0]        p;
    logic [COLOR_W-1:0] r;
    case (t)
      3'd0:    p = 24'h00ffff;
      3'd1:    p = 24'hffff00;
      3'd2:    p = 24'h800080;
      3'd3:    p = 24'h00ff00;
      3'd4:    p = 24'hff0000;
      3'd5:    p = 24'h0000ff;
      3'd6:    p = 24'hff8000;
      default: p = 24'hffffff;
    endcase
    r = '0;
    r[PW-1:0] = p[PW-1:0];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Position double buffer
  // ---------------------------------------------------------------------------
  logic          frame_start;
  logic [BW-1:0] pend_x, pend_y, act_x, act_y;
  logic [2:0]    pend_type, act_type;

  assign frame_start = addr_valid && (address == '0);

  // A load coinciding with frame start bypasses the pending buffer so the
  // frame that is just starting already uses the new positions.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_x         <= '1;
      pend_y         <= '1;
      pend_type      <= '0;
      act_x          <= '1;
      act_y          <= '1;
      act_type       <= '0;
      update_pending <= 1'b0;
    end else begin
      if (pos_load) begin
        pend_x    <= blk_x;
        pend_y    <= blk_y;
        pend_type <= blk_type;
      end
      if (frame_start && pos_load) begin
        act_x          <= blk_x;
        act_y          <= blk_y;
        act_type       <= blk_type;
        update_pending <= 1'b0;
      end else if (frame_start && update_pending) begin
        act_x          <= pend_x;
        act_y          <= pend_y;
        act_type       <= pend_type;
        update_pending <= 1'b0;
      end else if (pos_load) begin
        update_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: address -> (x, y)
  // ---------------------------------------------------------------------------
  logic               s1_valid, s1_oor;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [COLOR_W-1:0] s1_color;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= addr_valid;
      s1_oor   <= (address >= ADDR_W'(NPIX));
      s1_x     <= COORD_W'(address % ADDR_W'(H_RES));
      s1_y     <= COORD_W'(address / ADDR_W'(H_RES));
      s1_color <= color_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: per-cell hit test, lowest index wins
  // ---------------------------------------------------------------------------
  logic               hit_any, edge_any, blank;
  logic               in_x, in_y;
  logic [COORD_W-1:0] bx, by, lx, ly;

  assign blank = game_over && frame_count[BLINK_LOG2];

  // Upper bounds use one extra bit so an all-ones origin cannot wrap around
  // and match small coordinates.
  always_comb begin
    hit_any  = 1'b0;
    edge_any = 1'b0;
    in_x     = 1'b0;
    in_y     = 1'b0;
    bx       = '0;
    by       = '0;
    lx       = '0;
    ly       = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      bx   = act_x[i*COORD_W +: COORD_W];
      by   = act_y[i*COORD_W +: COORD_W];
      in_x = (s1_x >= bx) && ({1'b0, s1_x} < ({1'b0, bx} + CELL_EXT));
      in_y = (s1_y >= by) && ({1'b0, s1_y} < ({1'b0, by} + CELL_EXT));
      lx   = s1_x - bx;
      ly   = s1_y - by;
      if (in_x && in_y && !hit_any) begin
        hit_any  = 1'b1;
        edge_any = (lx == '0) || (lx == CELL_LAST) ||
                   (ly == '0) || (ly == CELL_LAST);
      end
    end
  end

  logic               s2_valid, s2_show, s2_edge;
  logic [2:0]         s2_type;
  logic [COLOR_W-1:0] s2_color;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_show  <= 1'b0;
      s2_edge  <= 1'b0;
      s2_type  <= '0;
      s2_color <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_show  <= hit_any && !s1_oor && !blank;
      s2_edge  <= edge_any;
      s2_type  <= act_type;
      s2_color <= s1_color;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: colour select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      color_valid <= 1'b0;
      color_out   <= '0;
    end else begin
      color_valid <= s2_valid;
      if (!s2_show) begin
        color_out <= s2_color;
      end else if (s2_edge) begin
        color_out <= '0;
      end else begin
        color_out <= palette(s2_type);
      end
    end
  end

endmodule

// File: tb/tb_tetris_pixel_renderer.sv
// Testbench for tetris_pixel_renderer. Uses a reduced 160x120 screen so
// whole frames can be streamed quickly; frame starts are also produced by
// sending address 0 on its own.
module tb_tetris_pixel_renderer;

  localparam int NB = 4;
  localparam int CS = 20;
  localparam int CW = 10;
  localparam int AW = 19;
  localparam int HR = 160;
  localparam int VR = 120;
  localparam int CLW = 24;
  localparam int BL = 4;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [AW-1:0]     address = '0;
  logic              addr_valid = 1'b0;
  logic [CLW-1:0]    color_in = '0;
  logic [NB*CW-1:0]  blk_x = '1;
  logic [NB*CW-1:0]  blk_y = '1;
  logic [2:0]        blk_type = '0;
  logic              pos_load = 1'b0;
  logic              game_over = 1'b0;
  logic [CLW-1:0]    color_out;
  logic              color_valid;
  logic [7:0]        frame_count;
  logic              update_pending;

  tetris_pixel_renderer #(
    .NUM_BLOCKS(NB), .CELL_SIZE(CS), .COORD_W(CW), .ADDR_W(AW),
    .H_RES(HR), .V_RES(VR), .COLOR_W(CLW), .BLINK_LOG2(BL)
  ) dut (
    .clock(clock), .resetn(resetn), .address(address), .addr_valid(addr_valid),
    .color_in(color_in), .blk_x(blk_x), .blk_y(blk_y), .blk_type(blk_type),
    .pos_load(pos_load), .game_over(game_over), .color_out(color_out),
    .color_valid(color_valid), .frame_count(frame_count),
    .update_pending(update_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          a;
    logic [23:0] e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fc = 0;
  logic [2:0] vpipe;

  function automatic logic [23:0] cin(input int a);
    return 24'(a) ^ 24'hA5A5A5;
  endfunction

  function automatic int pa(input int x, input int y);
    return y * HR + x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int a, input logic [23:0] e, input bit pl = 1'b0);
    exp_t it;
    address    = AW'(a);
    color_in   = cin(a);
    addr_valid = 1'b1;
    pos_load   = pl;
    it.a = a;
    it.e = e;
    exp_q.push_back(it);
    if (a == 0) fc = (fc + 1) % 256;
    @(posedge clock);
    #1;
    addr_valid = 1'b0;
    pos_load   = 1'b0;
  endtask

  task automatic idle();
    addr_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic set_blk(input int i, input int x, input int y);
    blk_x[i*CW +: CW] = CW'(x);
    blk_y[i*CW +: CW] = CW'(y);
  endtask

  // Reference valid timing: addr_valid delayed by three edges.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) vpipe <= '0;
    else         vpipe <= {vpipe[1:0], addr_valid};
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    if (resetn) begin
      check("valid_align", 32'(color_valid), 32'(vpipe[2]));
      if (color_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pixel: got %h with nothing expected (t=%0t)", color_out, $time);
        end else begin
          exp_t it;
          it = exp_q.pop_front();
          check($sformatf("pixel@%0d", it.a), 32'(color_out), 32'(it.e));
        end
      end
    end
  end

  int          tbl_a [5];
  logic [23:0] tbl_e [5];

  initial begin
    // ---- reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_color_valid", 32'(color_valid), 0);
    check("rst_color_out", 32'(color_out), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_update_pending", 32'(update_pending), 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // ---- frame 1: block0 loaded mid-frame, whole frame is background
    set_blk(0, 50, 50);
    blk_type = 3'd4;
    for (int a = 0; a < HR * VR; a++) begin
      send(a, cin(a), a == 100);
      if (a == 100) check("pending_after_load", 32'(update_pending), 1);
    end

    // ---- frame 2: commit and draw block0 at (50,50)
    send(0, cin(0));
    check("pending_cleared", 32'(update_pending), 0);
    check("frame_count_2", 32'(frame_count), 2);
    send(pa(60, 60), 24'hff0000);
    send(pa(50, 55), 24'h000000);
    send(pa(70, 60), cin(pa(70, 60)));
    send(pa(69, 69), 24'h000000);
    send(pa(68, 68), 24'hff0000);

    // ---- mid-frame load to (100,100): current frame unchanged
    set_blk(0, 100, 100);
    send(pa(60, 60), 24'hff0000, 1'b1);
    check("pending_mid_frame", 32'(update_pending), 1);
    send(pa(105, 105), cin(pa(105, 105)));
    send(pa(60, 60), 24'hff0000);
    send(0, cin(0));
    check("pending_commit", 32'(update_pending), 0);
    send(pa(105, 105), 24'hff0000);
    send(pa(60, 60), cin(pa(60, 60)));

    // ---- load coincident with frame start: same frame uses new position
    set_blk(0, 20, 30);
    blk_type = 3'd2;
    send(0, cin(0), 1'b1);
    check("pending_coincident", 32'(update_pending), 0);
    send(pa(25, 35), 24'h800080);
    send(pa(20, 30), 24'h000000);
    send(pa(24, 49), 24'h000000);
    send(pa(24, 50), cin(pa(24, 50)));
    send(pa(105, 105), cin(pa(105, 105)));

    // ---- overlap priority, all-ones origin, out-of-range
    set_blk(0, 120, 80);
    set_blk(1, 115, 75);
    set_blk(2, 1023, 0);
    set_blk(3, 0, 120);
    blk_type = 3'd0;
    pos_load = 1'b1;
    idle();
    pos_load = 1'b0;
    check("pending_load_only", 32'(update_pending), 1);
    send(0, cin(0));
    send(pa(120, 85), 24'h000000);
    send(pa(116, 85), 24'h00ffff);
    send(pa(125, 85), 24'h00ffff);
    send(pa(139, 90), 24'h000000);
    send(pa(140, 90), cin(pa(140, 90)));
    send(pa(159, 5), cin(pa(159, 5)));
    send(pa(5, 125), cin(pa(5, 125)));
    send(HR * VR, cin(HR * VR));

    // ---- game-over blink across a frame_count wrap
    game_over = 1'b1;
    for (int k = 0; k < 260; k++) begin
      send(0, cin(0));
      check("blink_frame_count", 32'(frame_count), 32'(fc));
      send(pa(125, 85), ((fc / 16) % 2 == 0) ? 24'h00ffff : cin(pa(125, 85)));
    end
    game_over = 1'b0;

    // ---- random valid gaps
    tbl_a[0] = pa(120, 85);  tbl_e[0] = 24'h000000;
    tbl_a[1] = pa(116, 85);  tbl_e[1] = 24'h00ffff;
    tbl_a[2] = pa(125, 85);  tbl_e[2] = 24'h00ffff;
    tbl_a[3] = pa(140, 90);  tbl_e[3] = cin(pa(140, 90));
    tbl_a[4] = pa(5, 125);   tbl_e[4] = cin(pa(5, 125));
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else send(tbl_a[k % 5], tbl_e[k % 5]);
    end

    // ---- reset mid-stream with pixels in flight
    send(tbl_a[1], tbl_e[1]);
    send(tbl_a[2], tbl_e[2]);
    resetn = 1'b0;
    #1;
    check("reset_flush_valid", 32'(color_valid), 0);
    exp_q.delete();
    fc = 0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    check("post_reset_frame_count", 32'(frame_count), 0);
    check("post_reset_pending", 32'(update_pending), 0);
    for (int k = 0; k < 5; k++) send(tbl_a[k], cin(tbl_a[k]));

    repeat (6) @(posedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tetris_pixel_renderer.md
Name: tetris_pixel_renderer

Overview:
Parametrised, pipelined successor of the single-block VGA colour processor. Takes the pixel address stream from the VGA controller plus the background colour and overlays NUM_BLOCKS falling-piece cells, each CELL_SIZE pixels square. Each cell is drawn with a per-type palette colour and a 1-pixel black outline. Position updates are double-buffered and committed only at frame start, so there is no tearing. A game-over blink mode is included. Sits between the VGA address generator / background ROM and the VGA DAC output.

Parameters:
NUM_BLOCKS, 4, number of cells overlaid (1..8).
CELL_SIZE, 20, cell edge length in pixels (>=3).
COORD_W, 10, width of one pixel coordinate.
ADDR_W, 19, pixel address width.
H_RES, 640, pixels per line; address = y*H_RES + x.
V_RES, 480, visible lines.
COLOR_W, 24, RGB colour width.
BLINK_LOG2, 4, game-over blink half-period is 2^BLINK_LOG2 frames (<=7).

Ports:
clock  in  1  system clock, all logic on rising edge.
resetn  in  1  asynchronous active-low reset.
address  in  ADDR_W  current pixel address.
addr_valid  in  1  address/color_in valid this cycle.
color_in  in  COLOR_W  background colour for address.
blk_x  in  NUM_BLOCKS*COORD_W  packed cell x origins; block i at [i*COORD_W +: COORD_W].
blk_y  in  NUM_BLOCKS*COORD_W  packed cell y origins, same packing.
blk_type  in  3  piece type for all cells.
pos_load  in  1  one-cycle pulse; captures blk_x/blk_y/blk_type.
game_over  in  1  level; enables blink.
color_out  out  COLOR_W  final pixel colour.
color_valid  out  1  color_out valid.
frame_count  out  8  frames started since reset, wraps 255->0.
update_pending  out  1  captured position not yet committed.

Behaviour:
- Reset (async, resetn=0): pending and active x/y registers all-ones; types = 0; update_pending=0; frame_count=0; color_out=0; color_valid=0; pipeline valids=0. Reset mid-frame drops all in-flight pixels.
- frame_start = addr_valid && address==0.
- Load/commit:
  - pos_load alone: pending <= inputs; update_pending=1.
  - frame_start with update_pending=1: active <= pending; update_pending=0.
  - pos_load and frame_start in the same cycle: active <= input buses directly; pending <= inputs; update_pending=0.
  - pos_load while already pending: overwrites pending.
- frame_count increments on every frame_start.
- Pipeline, fixed latency 3. color_valid(t+3) = addr_valid(t); no stalls; addr_valid=0 bubbles propagate.
  - S1: register x = address % H_RES, y = address / H_RES, color_in, valid. Set out_of_range when address >= H_RES*V_RES.
  - S2: per block i, hit_i = x>=bx_i && x<bx_i+CELL_SIZE && y>=by_i && y<by_i+CELL_SIZE. Sums are computed in COORD_W+1 bits, so all-ones positions never hit. Edge_i = hit with local offset 0 or CELL_SIZE-1 on either axis. Lowest-index hit wins. Register hit, edge and color.
  - S3: color_out =
    - color_in if no hit, out_of_range, or blank;
    - 000000 on edge;
    - otherwise palette[type].
  - blank = game_over && frame_count[BLINK_LOG2]==1, sampled in S2.
- Palette: 0 00ffff, 1 ffff00, 2 800080, 3 00ff00, 4 ff0000, 5 0000ff, 6 ff8000, 7 ffffff. Zero-extended or truncated to COLOR_W from the LSB.
- Overlapping cells are legal; output equals the lowest-index cell.
- Active positions stay constant for a whole frame regardless of pos_load timing.

Test Plan:
1. Reset, pos_load with block0=(50,50), type 4, others all-ones; then stream address 0..H_RES*V_RES-1 -> frame 1 is all color_in. From frame 2: pixel (60,60), address 38460, gives ff0000 three cycles after input; (50,55) gives 000000; (70,60) gives color_in.
2. pos_load mid-frame moving block0 to (100,100) -> rest of current frame still shows (50,50); update_pending=1 until next address 0, then cleared. The new frame shows (100,100).
3. pos_load coincident with address 0 -> the same frame uses the new positions; update_pending stays 0.
4. Blocks 0 and 1 both at (200,200) with type 0; pixel (205,205) -> 00ffff. Block at x=1023 never hits at any pixel.
5. game_over=1, BLINK_LOG2=4 -> blocks visible in frames with frame_count 0-15, replaced by color_in for 16-31, visible again 32-47. frame_count wraps 255->0.
6. Random addr_valid gaps -> color_valid exactly mirrors addr_valid delayed 3. Assert resetn low mid-stream -> color_valid=0 immediately, with no stale pixel after release.
